// File: rtl/alu_op_sequencer.sv
// Multicycle ALU controller that shares one W-bit adder and one inverter
// across ADD/SUB/AND/OR/NOT and a W-step shift-add MUL.
module alu_op_sequencer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         carry,
  output logic         err
);
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [2:0] {S_IDLE, S_INV, S_EXEC, S_MUL, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q, opb_q;
  logic            cin_q;
  logic [W-1:0]    acc, mcand, mplier;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    add_x, add_y, inv_in, inv_out, acc_nxt;
  logic            add_cin;
  logic [W:0]      sum;
  logic [W-1:0]    exec_res;
  logic            exec_c, exec_e;

  // The single adder: MUL accumulates, otherwise a + opB + cin.
  always_comb begin
    if (state == S_MUL) begin
      add_x   = acc;
      add_y   = mcand;
      add_cin = 1'b0;
    end else begin
      add_x   = a_q;
      add_y   = opb_q;
      add_cin = cin_q;
    end
  end
  assign sum = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

  // The single inverter: complements opB for SUB, operand A for NOT.
  assign inv_in  = (state == S_INV) ? opb_q : a_q;
  assign inv_out = ~inv_in;

  assign acc_nxt = mplier[0] ? sum[W-1:0] : acc;

  always_comb begin
    exec_res = '0;
    exec_c   = 1'b0;
    exec_e   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        exec_res = sum[W-1:0];
        exec_c   = sum[W];
      end
      OP_AND:  exec_res = a_q & opb_q;
      OP_OR:   exec_res = a_q | opb_q;
      OP_NOT:  exec_res = inv_out;
      default: exec_e   = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) begin
        if (op == OP_SUB)      state_nxt = S_INV;
        else if (op == OP_MUL) state_nxt = S_MUL;
        else                   state_nxt = S_EXEC;
      end
      S_INV:  state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_DONE;
      S_MUL:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      opb_q  <= '0;
      cin_q  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q   <= op;
          a_q    <= a;
          opb_q  <= b;
          cin_q  <= 1'b0;
          acc    <= '0;
          mcand  <= a;
          mplier <= b;
          cnt    <= CW'(W-1);
        end
        S_INV: begin
          opb_q <= inv_out;
          cin_q <= 1'b1;
        end
        S_EXEC: begin
          result <= exec_res;
          zero   <= (exec_res == '0);
          carry  <= exec_c;
          err    <= exec_e;
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == '0) begin
            result <= acc_nxt;
            zero   <= (acc_nxt == '0);
            carry  <= 1'b0;
            err    <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
endmodule
